// File: rtl/piso_pkg.sv
// Shared definitions for the piso_reg parallel-in serial-out shifter:
// FSM state encoding and the default word width.
package piso_pkg;

    localparam int unsigned PISO_DEFAULT_BW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } piso_state_e;

endpackage

// File: rtl/piso_skid_buf.sv
// One-entry valid/ready holding register used by piso_reg when built with
// PISO_SKID_EN; ready to accept whenever it is empty.
module piso_skid_buf
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_DEFAULT_BW
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (push_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
        end else if (pop_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_reg.sv
// Parallel-in serial-out shifter: MSB-first, one bit per shift_en_i strobe,
// plus a trailing flush strobe. Define PISO_SKID_EN for a one-entry input buffer.
module piso_reg
    import piso_pkg::*;
#(
    parameter int unsigned OUTPUT_BW = PISO_DEFAULT_BW
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [OUTPUT_BW-1:0] din_bus_i,
    input  logic                 din_valid_i,
    output logic                 din_ready_o,
    input  logic                 shift_en_i,
    output logic                 serial_data_o,
    output logic                 wr_en_o,
    output logic                 busy_o
);

    localparam int unsigned CNT_W = $clog2(OUTPUT_BW) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUTPUT_BW - 1);

    piso_state_e          state_q, state_d;
    logic [OUTPUT_BW-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 serial_q, serial_d;
    logic                 wr_en_q, wr_en_d;

    logic                 accept;
    logic                 load_en;
    logic [OUTPUT_BW-1:0] load_word;
    logic                 flush_done;

    assign flush_done = (state_q == FLUSH) && shift_en_i;
    assign accept     = din_valid_i && din_ready_o;

`ifdef PISO_SKID_EN
    logic                 skid_valid;
    logic [OUTPUT_BW-1:0] skid_data;
    logic                 load_direct;
    logic                 load_skid;

    // Shifter takes the buffered word first; a fresh word bypasses the buffer
    // only when the shifter is free to load on this edge.
    assign din_ready_o = reset_n_i && !skid_valid;
    assign load_skid   = skid_valid && ((state_q == IDLE) || flush_done);
    assign load_direct = accept && ((state_q == IDLE) || flush_done);
    assign load_en     = load_skid || load_direct;
    assign load_word   = load_skid ? skid_data : din_bus_i;

    piso_skid_buf #(
        .WIDTH (OUTPUT_BW)
    ) u_skid (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (accept && !load_direct),
        .data_i    (din_bus_i),
        .pop_i     (load_skid),
        .valid_o   (skid_valid),
        .data_o    (skid_data)
    );
`else
    assign din_ready_o = reset_n_i && (state_q == IDLE);
    assign load_en     = accept;
    assign load_word   = din_bus_i;
`endif

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        serial_d = serial_q;
        wr_en_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    sreg_d  = load_word;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en_i) begin
                    serial_d = sreg_q[OUTPUT_BW-1];
                    wr_en_d  = 1'b1;
                    sreg_d   = {sreg_q[OUTPUT_BW-2:0], 1'b0};
                    // Counter parks on the last bit index instead of wrapping.
                    if (cnt_q == LAST_BIT) begin
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (shift_en_i) begin
                    wr_en_d  = 1'b1;
                    serial_d = 1'b0;
                    if (load_en) begin
                        sreg_d  = load_word;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
            wr_en_q  <= wr_en_d;
        end
    end

    assign serial_data_o = serial_q;
    assign wr_en_o       = wr_en_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_piso_reg.sv
// Self-checking bench for piso_reg: directed and random stimulus against a
// bit-stream scoreboard plus a behavioural downstream deserializer.
module tb_piso_reg;

    localparam int unsigned BW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [BW-1:0] din_bus;
    logic          din_valid;
    logic          din_ready;
    logic          shift_en;
    logic          serial;
    logic          wr_en;
    logic          busy;

    logic [4:0]    d5_bus;
    logic          d5_valid;
    logic          d5_ready;
    logic          d5_shift;
    logic          d5_serial;
    logic          d5_wr_en;
    logic          d5_busy;

    always #5 clk = ~clk;

    piso_reg #(.OUTPUT_BW(BW)) u_dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .din_bus_i     (din_bus),
        .din_valid_i   (din_valid),
        .din_ready_o   (din_ready),
        .shift_en_i    (shift_en),
        .serial_data_o (serial),
        .wr_en_o       (wr_en),
        .busy_o        (busy)
    );

    piso_reg #(.OUTPUT_BW(5)) u_dut5 (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .din_bus_i     (d5_bus),
        .din_valid_i   (d5_valid),
        .din_ready_o   (d5_ready),
        .shift_en_i    (d5_shift),
        .serial_data_o (d5_serial),
        .wr_en_o       (d5_wr_en),
        .busy_o        (d5_busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: expected strobe stream, accepted words, downstream SIPO
    logic          exp_q[$];
    logic [BW-1:0] acc_q[$];
    logic [BW-1:0] sipo_word;
    int            sipo_cnt;
    int            cycle;
    int            strobe_cycles[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic clear_model();
        exp_q.delete();
        acc_q.delete();
        sipo_cnt  = 0;
        sipo_word = '0;
    endtask

    task automatic tick(input logic v, input logic [BW-1:0] d, input logic se, output logic fired);
        logic prev_se;
        din_valid = v;
        din_bus   = d;
        shift_en  = se;
        @(negedge clk);
        fired   = din_valid && din_ready;
        prev_se = shift_en;
        @(posedge clk);
        #1;
        cycle++;
        if (fired) begin
            for (int i = BW - 1; i >= 0; i--) exp_q.push_back(d[i]);
            exp_q.push_back(1'b0);
            acc_q.push_back(d);
        end
        if (wr_en) begin
            strobe_cycles.push_back(cycle);
            if (exp_q.size() == 0) check_eq("extra_strobe", wr_en, 0);
            else check_eq("serial_bit", serial, exp_q.pop_front());
            if (sipo_cnt == BW) begin
                if (acc_q.size() == 0) check_eq("deser_unexpected", wr_en, 0);
                else check_eq("deser_word", sipo_word, acc_q.pop_front());
                sipo_cnt = 0;
            end else begin
                sipo_word = {sipo_word[BW-2:0], serial};
                sipo_cnt++;
            end
        end
        check_eq("wr_gate", wr_en & ~prev_se, 0);
        check_eq("busy", busy, exp_q.size() != 0);
`ifndef PISO_SKID_EN
        check_eq("ready", din_ready, exp_q.size() == 0);
`endif
    endtask

    task automatic drain(input int mode, output int busy_cycles);
        logic f;
        logic se;
        busy_cycles = 0;
        for (int k = 0; k < 300; k++) begin
            if (!busy) break;
            busy_cycles++;
            if (mode == 0)      se = 1'b1;
            else if (mode == 1) se = (k % 2 == 0);
            else                se = ($urandom_range(0, 3) != 0);
            tick(1'b0, '0, se, f);
        end
        check_eq("drain_done", busy, 0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        din_valid = 1'b0;
        shift_en  = 1'b0;
        d5_valid  = 1'b0;
        d5_shift  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_serial", serial, 0);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", din_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_model();
        #1;
        check_eq("ready_after_rst", din_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic directed_word(input logic [BW-1:0] w, input int mode, input int exp_busy);
        logic f;
        int   s0, c0, bc;
        s0 = strobe_cycles.size();
        tick(1'b1, w, 1'b1, f);
        check_eq("accept", f, 1);
        c0 = cycle;
        drain(mode, bc);
        check_eq("strobe_count", strobe_cycles.size() - s0, BW + 1);
        check_eq("first_latency", strobe_cycles[s0] - c0, 1);
        if (exp_busy > 0) check_eq("busy_cycles", bc, exp_busy);
        if (mode == 1) check_eq("strobe_span", strobe_cycles[s0 + BW] - strobe_cycles[s0] + 1, 2 * BW + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          f;
        int            s0, idx, bc;
        logic [BW-1:0] words[2];
        logic [4:0]    w5;
        logic          bits5[$];

        cycle   = 0;
        din_bus = '0;
        d5_bus  = '0;
        clear_model();
        do_reset();

        // 0xA5 with shift_en constantly high
        directed_word(8'hA5, 0, BW + 1);
        // 0x3C with shift_en toggling
        directed_word(8'h3C, 1, 0);

        // Back-to-back words with din_valid held
        words[0] = 8'hFF;
        words[1] = 8'h01;
        idx = 0;
        s0  = strobe_cycles.size();
        for (int k = 0; k < 40 && idx < 2; k++) begin
            tick(1'b1, words[idx], 1'b1, f);
            if (f) idx++;
        end
        check_eq("b2b_accepted", idx, 2);
        drain(0, bc);
        check_eq("b2b_strobes", strobe_cycles.size() - s0, 2 * (BW + 1));
`ifdef PISO_SKID_EN
        check_eq("b2b_gap", strobe_cycles[s0 + BW + 1] - strobe_cycles[s0 + BW], 1);
`else
        check_eq("b2b_gap", strobe_cycles[s0 + BW + 1] - strobe_cycles[s0 + BW], 2);
`endif

        // Reset asserted after four bits of 0xA5
        tick(1'b1, 8'hA5, 1'b1, f);
        for (int k = 0; k < 4; k++) tick(1'b0, '0, 1'b1, f);
        check_eq("pre_rst_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_wr_en", wr_en, 0);
        check_eq("async_busy", busy, 0);
        check_eq("async_serial", serial, 0);
        do_reset();
        directed_word(8'h5A, 0, BW + 1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            tick(1'($urandom_range(0, 1)), BW'($urandom), 1'($urandom_range(0, 3) != 0), f);
        end
        drain(2, bc);
        check_eq("final_queue_empty", exp_q.size(), 0);
        check_eq("final_acc_empty", acc_q.size(), 0);

        // Narrow instance: 5-bit word 10011
        w5       = 5'b10011;
        d5_bus   = w5;
        d5_valid = 1'b1;
        d5_shift = 1'b1;
        @(posedge clk);
        #1;
        d5_valid = 1'b0;
        d5_bus   = 5'b01100;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (d5_wr_en) bits5.push_back(d5_serial);
        end
        check_eq("bw5_strobes", bits5.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < bits5.size()) check_eq("bw5_bit", bits5[i], (i < 5) ? w5[4 - i] : 1'b0);
        end
        check_eq("bw5_busy_end", d5_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
